// File: rtl/onehot_seq_pkg.sv
// Shared encodings for the one-hot sequencer.
//   mode_e : operating mode select (hold / load / rotate / bounce)
//   dir_e  : step direction, used for the rotate dir input and the bounce state
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/onehot_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while enabled and not cleared, and
// flags a tick on the cycle the count sits at PRESCALE-1.
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   clear  : synchronous counter clear (dominates enable)
//   enable : count enable; when low the counter is cleared
//   tick   : high on the last cycle of each PRESCALE-cycle period
module onehot_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // At least one bit so PRESCALE=1 still has a legal (always-zero) counter.
  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// Registered one-hot sequencer. Holds an index and drives its one-hot image;
// the index can be held, loaded, rotated with wrap-around, or bounced between
// the ends at a prescaled step rate.
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset
//   enable      : output gate and step-counter enable
//   mode        : 00 hold, 01 load, 10 rotate, 11 bounce
//   dir         : rotate direction (0 up, 1 down), rotate mode only
//   binary_in   : index to load in load mode
//   decoder_out : registered one-hot image of the index, zero while disabled
//   index_out   : registered current index
//   wrap        : one-cycle pulse on a rotate wrap or bounce reversal
//   load_err    : one-cycle pulse when a load value is out of range
module onehot_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 4,
  parameter int unsigned OUT_SIZE = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [IN_SIZE-1:0]  binary_in,
  output logic [OUT_SIZE-1:0] decoder_out,
  output logic [IN_SIZE-1:0]  index_out,
  output logic                wrap,
  output logic                load_err
);

  // Explicit end index; with OUT_SIZE=2**IN_SIZE the +1/-1 arithmetic would
  // wrap on its own, but wrap detection still needs this compare.
  localparam logic [IN_SIZE-1:0] MaxIdx = IN_SIZE'(OUT_SIZE - 1);

  logic [IN_SIZE-1:0] index_q, next_index;
  dir_e               dir_q, next_dir;
  logic               next_wrap, next_load_err;
  logic               tick, cnt_clear;

  // Only rotate/bounce (mode[1]=1) run the step counter, so 10<->11 keeps it.
  assign cnt_clear = !mode[1];

  onehot_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    next_index    = index_q;
    next_dir      = dir_q;
    next_wrap     = 1'b0;
    next_load_err = 1'b0;
    if (enable) begin
      unique case (mode)
        MODE_HOLD: begin
        end
        MODE_LOAD: begin
          // 32-bit compare so OUT_SIZE=2**IN_SIZE does not truncate to 0.
          if (32'(binary_in) < OUT_SIZE) begin
            next_index = binary_in;
            next_dir   = DIR_UP;
          end else begin
            next_load_err = 1'b1;
          end
        end
        MODE_ROT: begin
          if (tick) begin
            if (dir == DIR_UP) begin
              if (index_q == MaxIdx) begin
                next_index = '0;
                next_wrap  = 1'b1;
              end else begin
                next_index = index_q + IN_SIZE'(1);
              end
            end else begin
              if (index_q == '0) begin
                next_index = MaxIdx;
                next_wrap  = 1'b1;
              end else begin
                next_index = index_q - IN_SIZE'(1);
              end
            end
          end
        end
        MODE_BOUNCE: begin
          if (tick) begin
            if (dir_q == DIR_UP) begin
              if (index_q == MaxIdx) begin
                next_index = MaxIdx - IN_SIZE'(1);
                next_dir   = DIR_DN;
                next_wrap  = 1'b1;
              end else begin
                next_index = index_q + IN_SIZE'(1);
              end
            end else begin
              if (index_q == '0) begin
                next_index = IN_SIZE'(1);
                next_dir   = DIR_UP;
                next_wrap  = 1'b1;
              end else begin
                next_index = index_q - IN_SIZE'(1);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_q     <= '0;
      dir_q       <= DIR_UP;
      decoder_out <= '0;
      wrap        <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      index_q     <= next_index;
      dir_q       <= next_dir;
      decoder_out <= enable ? (OUT_SIZE'(1) << next_index) : '0;
      wrap        <= next_wrap;
      load_err    <= next_load_err;
    end
  end

  assign index_out = index_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
module tb_onehot_sequencer;
  import onehot_seq_pkg::*;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] binary_in;

  // u_a: defaults (16 outputs, PRESCALE=1)
  logic [15:0] dec_a;
  logic [3:0]  idx_a;
  logic        wrap_a, err_a;
  // u_b: PRESCALE=3
  logic [15:0] dec_b;
  logic [3:0]  idx_b;
  logic        wrap_b, err_b;
  // u_c: OUT_SIZE=10
  logic [9:0]  dec_c;
  logic [3:0]  idx_c;
  logic        wrap_c, err_c;

  int checks = 0;
  int errors = 0;

  onehot_sequencer u_a (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .binary_in(binary_in), .decoder_out(dec_a), .index_out(idx_a), .wrap(wrap_a),
    .load_err(err_a)
  );

  onehot_sequencer #(.IN_SIZE(4), .OUT_SIZE(16), .PRESCALE(3)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .binary_in(binary_in), .decoder_out(dec_b), .index_out(idx_b), .wrap(wrap_b),
    .load_err(err_b)
  );

  onehot_sequencer #(.IN_SIZE(4), .OUT_SIZE(10), .PRESCALE(1)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .binary_in(binary_in), .decoder_out(dec_c), .index_out(idx_c), .wrap(wrap_c),
    .load_err(err_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; mode = MODE_HOLD; dir = 1'b0; binary_in = 4'd0;
    #12;
    checks++;
    if (dec_a !== 16'h0000 || idx_a !== 4'd0 || wrap_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_held dec=%h idx=%0d wrap=%b err=%b expected 0000/0/0/0",
               dec_a, idx_a, wrap_a, err_a);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (dec_a !== 16'h0001 || idx_a !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_cycle dec=%h idx=%0d expected 0001/0", dec_a, idx_a);
    end
    checks++;
    if (wrap_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses wrap=%b err=%b expected 0/0", wrap_a, err_a);
    end
  endtask

  task automatic test_load_enable();
    mode = MODE_LOAD; binary_in = 4'd9;
    step();
    checks++;
    if (idx_a !== 4'd9 || dec_a !== 16'h0200 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL load9 idx=%0d dec=%h err=%b expected 9/0200/0", idx_a, dec_a, err_a);
    end
    mode = MODE_HOLD; enable = 1'b0;
    step();
    checks++;
    if (idx_a !== 4'd9 || dec_a !== 16'h0000) begin
      errors++;
      $display("FAIL disable_gate idx=%0d dec=%h expected 9/0000", idx_a, dec_a);
    end
    enable = 1'b1;
    step();
    checks++;
    if (idx_a !== 4'd9 || dec_a !== 16'h0200) begin
      errors++;
      $display("FAIL reenable idx=%0d dec=%h expected 9/0200", idx_a, dec_a);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_up [3] = '{4'd15, 4'd0, 4'd1};
    logic       wr_up  [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] exp_dn [2] = '{4'd0, 4'd15};
    logic       wr_dn  [2] = '{1'b0, 1'b1};
    mode = MODE_LOAD; binary_in = 4'd14;
    step();
    mode = MODE_ROT; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (idx_a !== exp_up[i] || wrap_a !== wr_up[i] || dec_a !== (16'h0001 << exp_up[i])) begin
        errors++;
        $display("FAIL rotate_up[%0d] idx=%0d wrap=%b dec=%h expected idx=%0d wrap=%b",
                 i, idx_a, wrap_a, dec_a, exp_up[i], wr_up[i]);
      end
    end
    mode = MODE_LOAD; binary_in = 4'd1;
    step();
    mode = MODE_ROT; dir = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (idx_a !== exp_dn[i] || wrap_a !== wr_dn[i] || dec_a !== (16'h0001 << exp_dn[i])) begin
        errors++;
        $display("FAIL rotate_dn[%0d] idx=%0d wrap=%b dec=%h expected idx=%0d wrap=%b",
                 i, idx_a, wrap_a, dec_a, exp_dn[i], wr_dn[i]);
      end
    end
    dir = 1'b0;
  endtask

  // PRESCALE=3 instance: a step lands on every third edge.
  task automatic test_bounce();
    logic [3:0] cur;
    logic [3:0] nxt;
    logic       exp_wrap;
    mode = MODE_LOAD; binary_in = 4'd0;
    step();
    mode = MODE_BOUNCE;
    cur = 4'd0;
    for (int s = 1; s <= 31; s++) begin
      nxt = (s <= 15) ? 4'(s) : ((s <= 30) ? 4'(30 - s) : 4'(s - 30));
      exp_wrap = (s == 16) || (s == 31);
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if (c < 2) begin
          if (idx_b !== cur || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL bounce_wait s=%0d c=%0d idx=%0d wrap=%b expected idx=%0d wrap=0",
                     s, c, idx_b, wrap_b, cur);
          end
        end else begin
          if (idx_b !== nxt || wrap_b !== exp_wrap || dec_b !== (16'h0001 << nxt)) begin
            errors++;
            $display("FAIL bounce_step s=%0d idx=%0d wrap=%b dec=%h expected idx=%0d wrap=%b",
                     s, idx_b, wrap_b, dec_b, nxt, exp_wrap);
          end
        end
      end
      cur = nxt;
    end
  endtask

  // Count survives a rotate->bounce switch; enable=0 clears it.
  task automatic test_prescale_keep();
    mode = MODE_LOAD; binary_in = 4'd3;
    step();
    mode = MODE_ROT; dir = 1'b0;
    step();
    step();
    checks++;
    if (idx_b !== 4'd3) begin
      errors++;
      $display("FAIL presc_pre idx=%0d expected 3", idx_b);
    end
    mode = MODE_BOUNCE;
    step();
    checks++;
    if (idx_b !== 4'd4) begin
      errors++;
      $display("FAIL presc_keep idx=%0d expected 4", idx_b);
    end
    step();
    enable = 1'b0;
    step();
    checks++;
    if (idx_b !== 4'd4 || dec_b !== 16'h0000) begin
      errors++;
      $display("FAIL presc_disabled idx=%0d dec=%h expected 4/0000", idx_b, dec_b);
    end
    enable = 1'b1;
    step();
    step();
    checks++;
    if (idx_b !== 4'd4) begin
      errors++;
      $display("FAIL presc_cleared idx=%0d expected 4", idx_b);
    end
    step();
    checks++;
    if (idx_b !== 4'd5 || dec_b !== 16'h0020) begin
      errors++;
      $display("FAIL presc_resume idx=%0d dec=%h expected 5/0020", idx_b, dec_b);
    end
  endtask

  task automatic test_out10();
    mode = MODE_LOAD; binary_in = 4'd5;
    step();
    checks++;
    if (idx_c !== 4'd5 || err_c !== 1'b0 || dec_c !== 10'h020) begin
      errors++;
      $display("FAIL o10_load5 idx=%0d err=%b dec=%h expected 5/0/020", idx_c, err_c, dec_c);
    end
    binary_in = 4'd12;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (idx_c !== 4'd5 || err_c !== 1'b1 || dec_c !== 10'h020) begin
        errors++;
        $display("FAIL o10_bad_load[%0d] idx=%0d err=%b dec=%h expected 5/1/020",
                 i, idx_c, err_c, dec_c);
      end
    end
    binary_in = 4'd9;
    step();
    checks++;
    if (idx_c !== 4'd9 || err_c !== 1'b0 || dec_c !== 10'h200) begin
      errors++;
      $display("FAIL o10_load9 idx=%0d err=%b dec=%h expected 9/0/200", idx_c, err_c, dec_c);
    end
    mode = MODE_ROT; dir = 1'b0;
    step();
    checks++;
    if (idx_c !== 4'd0 || wrap_c !== 1'b1 || dec_c !== 10'h001) begin
      errors++;
      $display("FAIL o10_wrap_up idx=%0d wrap=%b dec=%h expected 0/1/001", idx_c, wrap_c, dec_c);
    end
    step();
    checks++;
    if (idx_c !== 4'd1 || wrap_c !== 1'b0) begin
      errors++;
      $display("FAIL o10_after_wrap idx=%0d wrap=%b expected 1/0", idx_c, wrap_c);
    end
    mode = MODE_LOAD; binary_in = 4'd0;
    step();
    mode = MODE_ROT; dir = 1'b1;
    step();
    checks++;
    if (idx_c !== 4'd9 || wrap_c !== 1'b1 || dec_c !== 10'h200) begin
      errors++;
      $display("FAIL o10_wrap_dn idx=%0d wrap=%b dec=%h expected 9/1/200", idx_c, wrap_c, dec_c);
    end
    dir = 1'b0;
  endtask

  task automatic test_mid_reset();
    mode = MODE_LOAD; binary_in = 4'd0;
    step();
    mode = MODE_BOUNCE;
    // 15 steps up to 15, then 8 down to 7 (direction now down).
    for (int i = 0; i < 23; i++) step();
    checks++;
    if (idx_a !== 4'd7 || dec_a !== 16'h0080) begin
      errors++;
      $display("FAIL midrst_setup idx=%0d dec=%h expected 7/0080", idx_a, dec_a);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (idx_a !== 4'd0 || dec_a !== 16'h0000 || wrap_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async idx=%0d dec=%h wrap=%b err=%b expected 0/0000/0/0",
               idx_a, dec_a, wrap_a, err_a);
    end
    step();
    checks++;
    if (idx_a !== 4'd0 || dec_a !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_hold idx=%0d dec=%h expected 0/0000", idx_a, dec_a);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (idx_a !== 4'd0) begin
      errors++;
      $display("FAIL midrst_release idx=%0d expected 0", idx_a);
    end
    step();
    checks++;
    if (idx_a !== 4'd1 || dec_a !== 16'h0002 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_first idx=%0d dec=%h wrap=%b expected 1/0002/0", idx_a, dec_a, wrap_a);
    end
    step();
    checks++;
    if (idx_a !== 4'd2 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dir_up idx=%0d wrap=%b expected 2/0", idx_a, wrap_a);
    end
  endtask

  initial begin
    test_reset();
    test_load_enable();
    test_rotate();
    test_bounce();
    test_prescale_keep();
    test_out10();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
Parametrised, registered successor to the combinational binary-to-one-hot decoder.
- Holds a current index and drives its one-hot image on a registered output bus.
- The index can be loaded from a binary input, rotated with wrap-around, or swept back and forth (bounce), at a prescaled step rate.
- Drives board LED bars (LEDR chasers, selector displays) and one-hot select lines in lab designs.
- Registered boundaries on both sides make timing analysis direct.

Parameters:
- IN_SIZE, 4, width of binary_in and index_out.
- OUT_SIZE, 16, number of one-hot outputs; legal range 2 ≤ OUT_SIZE ≤ 2**IN_SIZE.
- PRESCALE, 1, clock cycles per step in modes 10/11; must be ≥ 1.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, output gate and step-counter enable.
- mode, input, 2, 00 hold, 01 load, 10 rotate, 11 bounce.
- dir, input, 1, rotate direction: 0 up, 1 down. Ignored outside mode 10.
- binary_in, input, IN_SIZE, index to load in mode 01.
- decoder_out, output, OUT_SIZE, registered one-hot image of the index, or 0 when disabled.
- index_out, output, IN_SIZE, registered current index.
- wrap, output, 1, one-cycle pulse on a rotate wrap or a bounce reversal.
- load_err, output, 1, one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high): index=0, decoder_out=0, wrap=0, load_err=0, bounce direction=up, prescale counter=0.
- All state updates occur on rising edges of clock. Every output is a register.
- decoder_out is registered from next_index: decoder_out <= enable ? (1 << next_index) : 0.
  - Latency from an input change to decoder_out is 1 cycle.
  - decoder_out has exactly one bit set while enable=1; it is all-zero while enable=0.
- enable=0: index holds, prescale counter clears, wrap=0, load_err=0.
- Mode 00 (hold): index unchanged; prescale counter clears.
- Mode 01 (load): acts every enabled cycle.
  - binary_in < OUT_SIZE: index <= binary_in; bounce direction resets to up.
  - binary_in ≥ OUT_SIZE: index holds; load_err pulses for 1 cycle (repeats every cycle the illegal input persists).
  - Prescale counter clears.
- Step tick: in modes 10/11 with enable=1, the counter counts 0..PRESCALE-1.
  - tick asserts when the counter equals PRESCALE-1; the counter then returns to 0.
  - PRESCALE=1 gives a tick every cycle.
  - The counter clears on any cycle in mode 00/01 or with enable=0. A mode change between 10 and 11 keeps the count.
- Mode 10 (rotate), on tick:
  - dir=0: index+1, wrapping OUT_SIZE-1 → 0.
  - dir=1: index-1, wrapping 0 → OUT_SIZE-1.
  - wrap pulses on the cycle the wrapped index is registered.
- Mode 11 (bounce), on tick:
  - Moves one step in the internal direction.
  - Going up at OUT_SIZE-1: index becomes OUT_SIZE-2, direction flips to down, wrap pulses.
  - Going down at 0: index becomes 1, direction flips to up, wrap pulses.
  - The end indices are therefore shown for a single step period.
- OUT_SIZE < 2**IN_SIZE: the index never reaches codes ≥ OUT_SIZE in any mode.
- Mid-operation reset: all state returns to reset values immediately, independent of clock. The first enabled cycle after release shows index 0.
- Index arithmetic is IN_SIZE bits. OUT_SIZE = 2**IN_SIZE relies on natural modulo wrap, but wrap detection compares explicitly against OUT_SIZE-1 / 0.

Decomposition:
- Package onehot_seq_pkg holds:
  - mode encodings: MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_ROT=2'b10, MODE_BOUNCE=2'b11;
  - direction constants DIR_UP=0, DIR_DN=1.
- One natural sub-module: onehot_prescaler, a PRESCALE-modulo tick counter with clear and enable inputs.
- The decode step is an inline shift, not a separate module.

Test Plan:
- Reset then enable=1, mode=00 → decoder_out=16'h0001, index_out=0 one cycle after reset release; wrap=0, load_err=0.
- mode=01, binary_in=4'd9 → next cycle index_out=9, decoder_out=16'h0200. Then enable=0 → decoder_out=0, index_out stays 9. Then enable=1 → decoder_out=16'h0200.
- mode=10, dir=0, PRESCALE=1, start index 14 → indices 15, 0, 1 on successive cycles; wrap high only on the cycle index_out=0. Repeat with dir=1 from 1 → 0, 15, with wrap on 15.
- mode=11, PRESCALE=3, start index 0 → index advances every 3rd cycle as 1, 2, … 15, 14, …; wrap pulses when 14 is registered after 15, and again when 1 is registered after 0.
- OUT_SIZE=10, IN_SIZE=4: load 4'd12 → load_err pulses, index unchanged. Rotate up from 9 → 0 with wrap, and decoder_out=10'h001.
- Assert reset mid-bounce (index 7, direction down) → outputs go to 0 asynchronously. After release with mode=11, PRESCALE=1 → index 1, direction up.
